// File: rtl/uart_pkg.sv
// Shared UART link constants: default line timing, receiver state encoding and
// the frame length used by both ends of the pipeline link.
package uart_pkg;

    localparam int unsigned DEFAULT_CLOCK_FREQ = 100_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE  = 9600;
    localparam int unsigned FRAME_BYTES        = 50;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    function automatic int unsigned calc_divisor(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer plus bit-level state machine.
// byte_valid/stop_err are combinational strobes on the mid-stop-bit sample cycle.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       clr,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_err,
    output logic       idle
);

    localparam int unsigned DIVISOR  = calc_divisor(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned HALF     = DIVISOR / 2;
    localparam logic [15:0] HALF_END = 16'(HALF - 1);
    localparam logic [15:0] BIT_END  = 16'(DIVISOR - 1);

    logic        rx_meta;
    logic        rx_s;
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_byte;
    logic        stop_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign stop_tick  = (state == STOP) && (cnt == BIT_END);
    assign byte_valid = stop_tick && rx_s;
    assign stop_err   = stop_tick && !rx_s;
    assign byte_data  = shift_byte;
    assign idle       = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_byte <= '0;
        end else if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                // Counting from mid-start keeps every later sample at mid-bit.
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt                 <= '0;
                        shift_byte[bit_idx] <= rx_s;
                        bit_idx             <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (stop_tick) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Packs NUM_BYTES received bytes (byte 0 in the LSBs) into one frame and
// publishes it atomically with a one-cycle frame_valid pulse.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int unsigned NUM_BYTES  = FRAME_BYTES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx,
    input  logic                             clr,
    output logic [8*NUM_BYTES-1:0]           data_out,
    output logic                             frame_valid,
    output logic                             busy,
    output logic                             framing_error,
    output logic [$clog2(NUM_BYTES+1)-1:0]   byte_cnt
);

    localparam int unsigned CW = $clog2(NUM_BYTES + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_BYTES - 1);

    logic [7:0]             byte_data;
    logic                   byte_valid;
    logic                   stop_err;
    logic                   rx_idle;
    logic [8*NUM_BYTES-1:0] frame_buf;
    logic [8*NUM_BYTES-1:0] next_buf;

    uart_rx_byte #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_rx_byte (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .clr        (clr),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .stop_err   (stop_err),
        .idle       (rx_idle)
    );

    // Buffer with the incoming byte merged in, so the final byte lands in
    // data_out on the same edge that accepts it.
    always_comb begin
        next_buf                          = frame_buf;
        next_buf[int'(byte_cnt) * 8 +: 8] = byte_data;
    end

    assign busy = !rx_idle || (byte_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_buf     <= '0;
            data_out      <= '0;
            frame_valid   <= 1'b0;
            framing_error <= 1'b0;
            byte_cnt      <= '0;
        end else begin
            frame_valid   <= 1'b0;
            framing_error <= 1'b0;
            if (clr) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                frame_buf <= next_buf;
                if (byte_cnt == LAST_SLOT) begin
                    data_out    <= next_buf;
                    frame_valid <= 1'b1;
                    byte_cnt    <= '0;
                end else begin
                    byte_cnt <= byte_cnt + CW'(1);
                end
            end else if (stop_err) begin
                framing_error <= 1'b1;
                byte_cnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 2-byte frames at 16 clocks/bit plus a
// 50-byte loopback against a bench-side 8N1 transmitter.
module tb_uart_rx_frame;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] data_out;
    logic        frame_valid;
    logic        busy;
    logic        framing_error;
    logic [1:0]  byte_cnt;

    logic        rx50 = 1'b1;
    logic [399:0] data_out50;
    logic        frame_valid50;
    logic        busy50;
    logic        framing_error50;
    logic [5:0]  byte_cnt50;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int fv50_cnt = 0;

    uart_rx_frame #(.CLOCK_FREQ(16), .BAUD_RATE(1), .NUM_BYTES(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .clr(clr),
        .data_out(data_out), .frame_valid(frame_valid), .busy(busy),
        .framing_error(framing_error), .byte_cnt(byte_cnt)
    );

    uart_rx_frame #(.CLOCK_FREQ(16), .BAUD_RATE(1), .NUM_BYTES(50)) dut50 (
        .clk(clk), .rst(rst), .rx(rx50), .clr(1'b0),
        .data_out(data_out50), .frame_valid(frame_valid50), .busy(busy50),
        .framing_error(framing_error50), .byte_cnt(byte_cnt50)
    );

    always #5 clk = ~clk;

    // Pulse counters: a pulse longer than one cycle shows up as an extra count.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (framing_error === 1'b1) fe_cnt++;
        if (frame_valid50 === 1'b1) fv50_cnt++;
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input bit sel, input logic v);
        if (sel) rx50 = v; else rx = v;
        repeat (16) @(posedge clk);
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, b[i]);
        send_bit(sel, 1'b1);
    endtask

    task automatic wait_fv(input int target);
        int n = 0;
        while (fv_cnt < target && n < 200) begin
            @(posedge clk);
            n++;
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int fv0, fe0;
        logic [399:0] word;

        vecs[0] = '{b0: 8'hA5, b1: 8'h3C, exp: 16'h3CA5};
        vecs[1] = '{b0: 8'h00, b1: 8'hFF, exp: 16'hFF00};
        vecs[2] = '{b0: 8'h80, b1: 8'h01, exp: 16'h0180};
        vecs[3] = '{b0: 8'h5A, b1: 8'hC3, exp: 16'hC35A};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset data_out", 64'(data_out), 64'h0);
        chk("reset frame_valid", 64'(frame_valid), 64'h0);
        chk("reset framing_error", 64'(framing_error), 64'h0);
        chk("reset byte_cnt", 64'(byte_cnt), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset data_out50", 64'(data_out50 == '0), 64'h1);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        for (int v = 0; v < 4; v++) begin
            fv0 = fv_cnt;
            fe0 = fe_cnt;
            send_byte(1'b0, vecs[v].b0);
            @(negedge clk);
            chk($sformatf("vec%0d byte_cnt mid", v), 64'(byte_cnt), 64'h1);
            send_byte(1'b0, vecs[v].b1);
            wait_fv(fv0 + 1);
            settle();
            chk($sformatf("vec%0d fv pulses", v), 64'(fv_cnt - fv0), 64'h1);
            chk($sformatf("vec%0d data_out", v), 64'(data_out), 64'(vecs[v].exp));
            chk($sformatf("vec%0d byte_cnt", v), 64'(byte_cnt), 64'h0);
            chk($sformatf("vec%0d busy", v), 64'(busy), 64'h0);
            chk($sformatf("vec%0d fe pulses", v), 64'(fe_cnt - fe0), 64'h0);
        end

        // Short low glitch while idle
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        chk("glitch busy in START", 64'(busy), 64'h1);
        repeat (24) @(negedge clk);
        chk("glitch busy", 64'(busy), 64'h0);
        chk("glitch byte_cnt", 64'(byte_cnt), 64'h0);
        chk("glitch pulses", 64'((fv_cnt - fv0) + (fe_cnt - fe0)), 64'h0);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h02);
        wait_fv(fv0 + 1);
        settle();
        chk("glitch frame data", 64'(data_out), 64'h0201);
        chk("glitch frame fv", 64'(fv_cnt - fv0), 64'h1);

        // Bad stop bit held low for three bit times
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0, i[0] ? 1'b0 : 1'b1);
        rx = 1'b0;
        repeat (48) @(posedge clk);
        @(negedge clk);
        chk("break fe pulses", 64'(fe_cnt - fe0), 64'h1);
        chk("break busy", 64'(busy), 64'h1);
        chk("break byte_cnt", 64'(byte_cnt), 64'h0);
        chk("break no frame", 64'(fv_cnt - fv0), 64'h0);
        chk("break data held", 64'(data_out), 64'h0201);
        rx = 1'b1;
        repeat (32) @(posedge clk);
        @(negedge clk);
        chk("break recovered busy", 64'(busy), 64'h0);
        send_byte(1'b0, 8'h11);
        send_byte(1'b0, 8'h22);
        wait_fv(fv0 + 1);
        settle();
        chk("break frame data", 64'(data_out), 64'h2211);
        chk("break frame fv", 64'(fv_cnt - fv0), 64'h1);
        chk("break fe total", 64'(fe_cnt - fe0), 64'h1);

        // clr after a partial frame
        fv0 = fv_cnt;
        send_byte(1'b0, 8'hFF);
        @(negedge clk);
        chk("clr pre byte_cnt", 64'(byte_cnt), 64'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr byte_cnt", 64'(byte_cnt), 64'h0);
        chk("clr busy", 64'(busy), 64'h0);
        chk("clr data_out held", 64'(data_out), 64'h2211);
        repeat (8) @(posedge clk);
        send_byte(1'b0, 8'h10);
        @(negedge clk);
        chk("clr no frame yet", 64'(fv_cnt - fv0), 64'h0);
        send_byte(1'b0, 8'h20);
        wait_fv(fv0 + 1);
        settle();
        chk("clr frame data", 64'(data_out), 64'h2010);
        chk("clr frame fv", 64'(fv_cnt - fv0), 64'h1);

        // Reset in the middle of the second byte
        send_byte(1'b0, 8'hAA);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, i[0]);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        @(negedge clk);
        chk("rst data_out", 64'(data_out), 64'h0);
        chk("rst byte_cnt", 64'(byte_cnt), 64'h0);
        chk("rst busy", 64'(busy), 64'h0);
        chk("rst pulses", 64'({frame_valid, framing_error}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("rst no stray pulses", 64'((fv_cnt - fv0) + (fe_cnt - fe0)), 64'h0);
        send_byte(1'b0, 8'h0F);
        send_byte(1'b0, 8'hF0);
        wait_fv(fv0 + 1);
        settle();
        chk("rst frame data", 64'(data_out), 64'hF00F);

        // 50-byte loopback
        for (int i = 0; i < 12; i++) word[32*i +: 32] = $urandom;
        word[399:384] = 16'($urandom);
        fv0 = fv50_cnt;
        for (int k = 0; k < 50; k++) send_byte(1'b1, word[8*k +: 8]);
        settle();
        checks++;
        if (data_out50 !== word) begin
            errors++;
            $display("FAIL loopback data_out50: got %h expected %h", data_out50, word);
        end
        chk("loopback fv pulses", 64'(fv50_cnt - fv0), 64'h1);
        chk("loopback byte_cnt", 64'(byte_cnt50), 64'h0);
        chk("loopback fe", 64'(framing_error50), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
